// File: rtl/wordgate_pkg.sv
// Shared op-code constants and payload sizing for the wordgate pipeline.
// Payload = result word plus carry, zero and op_err sideband bits.
package wordgate_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd4;

    localparam int SIDEBAND_W = 3;

    function automatic int payload_width(input int width);
        return width + SIDEBAND_W;
    endfunction

endpackage

// File: rtl/wordgate_stage.sv
// One elastic register slice: holds a valid flag and a payload, passes
// backpressure upstream as ready = ~valid | downstream ready.
module wordgate_stage #(
    parameter int PAYLOAD_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    assign in_ready    = ~valid_q | out_ready;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (in_ready) begin
            valid_d = in_valid;
            // NOTE: payload only loads on a real transfer, so idle (possibly X) inputs never reach out.
            if (in_valid) begin
                payload_d = in_payload;
            end
        end
    end

    // NOTE: non-blocking assignments keep every stage sampling pre-edge values of its neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/wordgate_pipe.sv
// Word gate: applies a broadcast control bit to an operand (PASS/XOR/AND/OR/NEG)
// and carries the result plus sidebands through a STAGES-deep elastic pipeline.
module wordgate_pipe
    import wordgate_pkg::*;
#(
    parameter int WIDTH  = 17,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             gate_bit,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero,
    output logic             op_err
);

    localparam int PAYLOAD_W = payload_width(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
        logic             op_err;
    } payload_t;

    payload_t         fn_result;
    logic [WIDTH-1:0] neg_sum;
    logic             neg_carry;

    always_comb begin
        // Carry of ~in + 1 is set only when in is all zeros.
        {neg_carry, neg_sum} = {1'b0, ~in} + {{WIDTH{1'b0}}, 1'b1};
        fn_result            = '0;
        fn_result.data       = in;
        case (op)
            OP_PASS: ;
            OP_XOR:  fn_result.data = in ^ {WIDTH{gate_bit}};
            OP_AND:  fn_result.data = in & {WIDTH{gate_bit}};
            OP_OR:   fn_result.data = in | {WIDTH{gate_bit}};
            OP_NEG: begin
                if (gate_bit) begin
                    fn_result.data  = neg_sum;
                    fn_result.carry = neg_carry;
                end
            end
            default: fn_result.op_err = 1'b1;
        endcase
        fn_result.zero = (fn_result.data == '0);
    end

    logic     valid_c   [STAGES+1];
    logic     ready_c   [STAGES+1];
    payload_t payload_c [STAGES+1];

    assign valid_c[0]      = in_valid;
    assign payload_c[0]    = fn_result;
    assign in_ready        = ready_c[0];
    assign ready_c[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        wordgate_stage #(
            .PAYLOAD_W (PAYLOAD_W)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (valid_c[k]),
            .in_ready    (ready_c[k]),
            .in_payload  (payload_c[k]),
            .out_valid   (valid_c[k+1]),
            .out_ready   (ready_c[k+1]),
            .out_payload (payload_c[k+1])
        );
    end

    assign out_valid = valid_c[STAGES];
    assign out       = payload_c[STAGES].data;
    assign carry_out = payload_c[STAGES].carry;
    assign zero      = payload_c[STAGES].zero;
    assign op_err    = payload_c[STAGES].op_err;

endmodule

// File: tb/tb_wordgate_pipe.sv
// Scoreboard bench for wordgate_pipe: one STAGES=2 instance for directed steps,
// STAGES=1 and STAGES=4 instances for a random valid/ready stream.
module tb_wordgate_pipe;

    localparam int W = 17;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        logic         err;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic [W-1:0] in_w      [N];
    logic         gate_bit  [N];
    logic [2:0]   op        [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [W-1:0] out_w     [N];
    logic         carry_out [N];
    logic         zero      [N];
    logic         op_err    [N];

    exp_t sb [N][$];
    int   cycle;
    int   last_stall [N];
    bit   accepted   [N];
    int   sent       [N];
    int   n_pass;
    int   n_total;

    always #5 clk = ~clk;

    wordgate_pipe #(.WIDTH(W), .STAGES(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(in_w[0]),
        .gate_bit(gate_bit[0]), .op(op[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out(out_w[0]), .carry_out(carry_out[0]), .zero(zero[0]), .op_err(op_err[0])
    );

    wordgate_pipe #(.WIDTH(W), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(in_w[1]),
        .gate_bit(gate_bit[1]), .op(op[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out(out_w[1]), .carry_out(carry_out[1]), .zero(zero[1]), .op_err(op_err[1])
    );

    wordgate_pipe #(.WIDTH(W), .STAGES(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in(in_w[2]),
        .gate_bit(gate_bit[2]), .op(op[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out(out_w[2]), .carry_out(carry_out[2]), .zero(zero[2]), .op_err(op_err[2])
    );

    function automatic int stg(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic exp_t model(input logic [W-1:0] d, input logic b, input logic [2:0] o);
        exp_t e;
        e.data  = d;
        e.carry = 1'b0;
        e.err   = 1'b0;
        e.cyc   = 0;
        case (o)
            3'd1: if (b) e.data = ~d;
            3'd2: if (!b) e.data = '0;
            3'd3: if (b) e.data = '1;
            3'd4: if (b) begin
                e.data  = W'(0) - d;
                e.carry = (d == '0);
            end
            3'd5, 3'd6, 3'd7: e.err = 1'b1;
            default: ;
        endcase
        e.zero = (e.data == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: sample at the falling edge, score transfers, advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            accepted[i] = 1'b0;
            if (!out_ready[i]) last_stall[i] = cycle;
            if (out_valid[i] === 1'b1 && out_ready[i]) begin
                if (sb[i].size() == 0) begin
                    check($sformatf("dut%0d_spurious_out_valid", i), out_valid[i], 0);
                end else begin
                    e = sb[i].pop_front();
                    check($sformatf("dut%0d_out", i), out_w[i], e.data);
                    check($sformatf("dut%0d_carry", i), carry_out[i], e.carry);
                    check($sformatf("dut%0d_zero", i), zero[i], e.zero);
                    check($sformatf("dut%0d_op_err", i), op_err[i], e.err);
                    if (last_stall[i] <= e.cyc)
                        check($sformatf("dut%0d_latency", i), cycle - e.cyc, stg(i));
                end
            end
            if (in_valid[i] && in_ready[i] === 1'b1) begin
                e     = model(in_w[i], gate_bit[i], op[i]);
                e.cyc = cycle;
                sb[i].push_back(e);
                accepted[i] = 1'b1;
                sent[i]++;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int i);
        in_valid[i] = 1'b0;
        in_w[i]     = 'x;
        gate_bit[i] = 1'bx;
        op[i]       = 'x;
    endtask

    task automatic send(input int i, input logic [W-1:0] d, input logic b, input logic [2:0] o);
        in_valid[i] = 1'b1;
        in_w[i]     = d;
        gate_bit[i] = b;
        op[i]       = o;
        for (int k = 0; k < 50; k++) begin
            step();
            if (accepted[i]) break;
        end
        if (!accepted[i]) check($sformatf("dut%0d_send_timeout", i), in_ready[i], 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
            step();
        end
        for (int i = 0; i < N; i++) check($sformatf("dut%0d_drain_empty", i), sb[i].size(), 0);
    endtask

    // Single op on the STAGES=2 instance with literal expectations two cycles later.
    task automatic directed(input string tag, input logic [W-1:0] d, input logic b,
                            input logic [2:0] o, input logic [W-1:0] exp_out,
                            input logic exp_c, input logic exp_z, input logic exp_e);
        send(0, d, b, o);
        idle(0);
        check({tag, "_not_early"}, out_valid[0], 0);
        step();
        check({tag, "_valid"}, out_valid[0], 1);
        check({tag, "_out"}, out_w[0], exp_out);
        check({tag, "_carry"}, carry_out[0], exp_c);
        check({tag, "_zero"}, zero[0], exp_z);
        check({tag, "_op_err"}, op_err[0], exp_e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        cycle   = 0;
        rst     = 1'b1;
        for (int i = 0; i < N; i++) begin
            idle(i);
            out_ready[i]  = 1'b1;
            last_stall[i] = -1;
            accepted[i]   = 1'b0;
            sent[i]       = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on all instances.
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst%0d_out_valid", i), out_valid[i], 0);
            check($sformatf("rst%0d_out", i), out_w[i], 0);
            check($sformatf("rst%0d_carry", i), carry_out[i], 0);
            check($sformatf("rst%0d_zero", i), zero[i], 0);
            check($sformatf("rst%0d_op_err", i), op_err[i], 0);
            check($sformatf("rst%0d_in_ready", i), in_ready[i], 1);
        end

        // Directed function vectors.
        directed("xor_b1",   17'h000FF, 1'b1, 3'd1, 17'h1FF00, 1'b0, 1'b0, 1'b0);
        directed("xor_b0",   17'h000FF, 1'b0, 3'd1, 17'h000FF, 1'b0, 1'b0, 1'b0);
        directed("neg_one",  17'h00001, 1'b1, 3'd4, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        directed("neg_zero", 17'h00000, 1'b1, 3'd4, 17'h00000, 1'b1, 1'b1, 1'b0);
        directed("neg_b0",   17'h00005, 1'b0, 3'd4, 17'h00005, 1'b0, 1'b0, 1'b0);
        directed("and_b0",   17'h0A5A5, 1'b0, 3'd2, 17'h00000, 1'b0, 1'b1, 1'b0);
        directed("or_b1",    17'h0A5A5, 1'b1, 3'd3, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        directed("rsvd_6",   17'h0A5A5, 1'b1, 3'd6, 17'h0A5A5, 1'b0, 1'b0, 1'b1);
        directed("pass",     17'h12345, 1'b1, 3'd0, 17'h12345, 1'b0, 1'b0, 1'b0);

        // Back-to-back throughput with out_ready high.
        send(0, 17'h00010, 1'b1, 3'd1);
        send(0, 17'h00020, 1'b1, 3'd4);
        send(0, 17'h00030, 1'b0, 3'd2);
        idle(0);
        drain();

        // Backpressure: pipeline fills after two accepts, output frozen.
        out_ready[0] = 1'b0;
        send(0, 17'h00001, 1'b1, 3'd1);
        send(0, 17'h00002, 1'b1, 3'd1);
        check("bp_in_ready_low", in_ready[0], 0);
        check("bp_out_valid", out_valid[0], 1);
        in_valid[0] = 1'b1;
        in_w[0]     = 17'h00003;
        repeat (3) step();
        check("bp_out_hold", out_w[0], 17'h1FFFE);
        check("bp_in_ready_still_low", in_ready[0], 0);
        check("bp_accepted_count", sb[0].size(), 2);
        out_ready[0] = 1'b1;
        send(0, 17'h00003, 1'b1, 3'd1);
        send(0, 17'h00004, 1'b1, 3'd1);
        idle(0);
        drain();

        // Reset with two results in flight: nothing may emerge afterwards.
        send(0, 17'h00111, 1'b1, 3'd1);
        send(0, 17'h00222, 1'b1, 3'd1);
        idle(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle++;
        for (int i = 0; i < N; i++) sb[i].delete();
        check("midrst_out_valid", out_valid[0], 0);
        check("midrst_out", out_w[0], 0);
        check("midrst_in_ready", in_ready[0], 1);
        repeat (6) step();
        check("midrst_no_stale", out_valid[0], 0);

        // Random stream on the STAGES=1 and STAGES=4 instances.
        sent[1] = 0;
        sent[2] = 0;
        for (int c = 0; c < 20000; c++) begin
            if (sent[1] >= 1000 && sent[2] >= 1000) break;
            for (int i = 1; i < N; i++) begin
                if (!in_valid[i] || accepted[i]) begin
                    if (sent[i] < 1000 && $urandom_range(3) != 0) begin
                        in_valid[i] = 1'b1;
                        in_w[i]     = ($urandom_range(7) == 0) ? '0 : W'($urandom);
                        gate_bit[i] = 1'($urandom_range(1));
                        op[i]       = 3'($urandom_range(7));
                    end else begin
                        idle(i);
                    end
                end
                out_ready[i] = ($urandom_range(3) != 0);
            end
            step();
        end
        idle(1);
        idle(2);
        out_ready[1] = 1'b1;
        out_ready[2] = 1'b1;
        drain();
        check("rand_s1_sent", sent[1], 1000);
        check("rand_s4_sent", sent[2], 1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wordgate_pipe.md
Name: wordgate_pipe

Overview:
- Parametrised, pipelined successor of the ALU's single-bit word gate.
- Applies a broadcast control bit to an operand word using one of several selectable modes: XOR, AND, OR, or conditional two's-complement negate.
- Results pass through a valid/ready elastic pipeline of configurable depth.
- Sits between the operand-select stage and the adder/logic core of the ALU, and provides backpressure.

Parameters:
- WIDTH, 17: operand/result width in bits (16 data + 1 extension bit); legal ≥ 2.
- STAGES, 2: pipeline register stages; latency in cycles; legal 1..4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op/bit present this cycle.
- in_ready  output  1  pipeline can accept this cycle.
- in  input  WIDTH  operand word.
- bit  input  1  broadcast control bit.
- op  input  3  mode select (see Behaviour).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result word.
- carry_out  output  1  NEG carry (see Behaviour); 0 for other modes.
- zero  output  1  out == 0.
- op_err  output  1  result came from a reserved op code.

Behaviour:
- Reset (rst high at a clock edge):
  - All stage valid flags are cleared.
  - out, carry_out, zero and op_err are driven to 0.
  - out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight results; no result emerges afterwards.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a clock edge.
  - Output transfer occurs when out_valid & out_ready.
- Op codes. The function is evaluated combinationally at the input and captured into stage 1. Later stages only delay.
  - 0 PASS: out = in.
  - 1 XOR: out = in ^ {WIDTH{bit}}.
  - 2 AND: out = in & {WIDTH{bit}}.
  - 3 OR: out = in | {WIDTH{bit}}.
  - 4 NEG: out = bit ? (~in + 1) mod 2^WIDTH : in. carry_out = bit & (in == 0), i.e. the carry of the +1.
  - 5–7 reserved: out = in, op_err = 1.
- Sidebands:
  - zero is computed at the input and pipelined with the result.
  - carry_out and op_err are pipelined with the result.
- Elastic pipeline:
  - Each stage k holds valid_k and its payload.
  - ready_k = ~valid_k | ready_{k+1}, where ready_{STAGES+1} = out_ready.
  - in_ready = ready_1.
  - A stage loads from its predecessor when ready_k is high. Otherwise it holds its payload unchanged.
  - out_valid and the out/sideband signals come from the last stage.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid, when there is no stall.
  - Throughput is 1 result per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the pipeline fills.
  - in_ready falls once all STAGES stages are valid.
  - Payloads never change while out_valid = 1 and out_ready = 0.
- Ordering: results emerge in input order. No loss, no duplication.
- Simultaneous push/pop at full occupancy with out_ready = 1: in_ready stays 1 and the pipeline advances every stage.
- Inputs are ignored when in_valid = 0; they may be X.

Decomposition:
- Package wordgate_pkg:
  - op code constants OP_PASS = 0, OP_XOR = 1, OP_AND = 2, OP_OR = 3, OP_NEG = 4.
  - Payload field widths: WIDTH + 3 sideband bits.
- One sub-module, wordgate_stage: a single elastic register slice, parametrised on payload width. It has valid/ready in and out, and synchronous reset clearing valid and payload.
- The top level contains the combinational op function and a generate loop of STAGES wordgate_stage instances.

Test Plan (WIDTH = 17, STAGES = 2 unless stated):
- XOR: in = 17'h000FF, bit = 1, op = 1 → out = 17'h1FF00 exactly 2 cycles later. With bit = 0, out = 17'h000FF.
- NEG:
  - in = 17'h00001, bit = 1, op = 4 → out = 17'h1FFFF, carry_out = 0.
  - in = 0, bit = 1 → out = 0, carry_out = 1, zero = 1.
  - in = 17'h00005, bit = 0 → out = 17'h00005.
- AND/OR/reserved:
  - in = 17'h0A5A5, bit = 0, op = 2 → out = 0, zero = 1.
  - op = 3, bit = 1 → 17'h1FFFF.
  - op = 6 → out = 17'h0A5A5, op_err = 1.
- Backpressure:
  - Hold out_ready = 0 and stream 4 XOR ops → in_ready drops after 2 accepts. out is held stable.
  - Then raise out_ready → the 4 results appear in order, one per cycle.
- Reset mid-operation: accept 2 ops, assert rst for 1 cycle → out_valid = 0 and out = 0. No stale result ever appears. in_ready = 1 next cycle.
- Random stream: 1000 ops with random in_valid/out_ready (STAGES = 1 and 4) → scoreboard matches the reference model in order, and latency equals STAGES when unstalled.
